// File: rtl/chiplet_types_pkg.sv
// chiplet_types_pkg: shared types and constants for the chiplet link datapath.
//   word_t        - 32-bit link word
//   node_id_t     - requestor node identifier
//   CRC32_*       - CRC-32/MPEG-2 polynomial and seed
//   rx_crc_state_t- receive-side CRC checker framing states
//   crc_result_t  - per-packet verdict {req, crc, ok, frame_err}
package chiplet_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  node_id_t;

  localparam word_t CRC32_POLY = 32'h04C11DB7;
  localparam word_t CRC32_INIT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK
  } rx_crc_state_t;

  typedef struct packed {
    node_id_t req;
    word_t    crc;
    logic     ok;
    logic     frame_err;
  } crc_result_t;

endpackage

// File: rtl/crc32_word_update.sv
// crc32_word_update: combinational CRC-32/MPEG-2 step over one 32-bit word.
// The word is consumed MSB first, i.e. byte [31:24] first, no reflection.
//   crc_i  - current CRC
//   data_i - word to fold in
//   crc_o  - CRC after folding data_i
module crc32_word_update
  import chiplet_types_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [31:0] data_i,
  output logic [31:0] crc_o
);

  always_comb begin
    logic [31:0] c;
    logic        fb;
    c  = crc_i;
    fb = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      fb = c[31] ^ data_i[31 - i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : '0);
    end
    crc_o = c;
  end

endmodule

// File: rtl/rx_crc_checker.sv
// rx_crc_checker: receive-side integrity stage. Tracks packet framing
// (header beat, len payload beats, trailing CRC beat), accumulates a
// CRC-32/MPEG-2 over the payload, and emits a per-packet verdict.
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid/in_ready     - incoming word stream handshake
//   in_sop, in_req, in_len- header beat marker and its fields
//   in_data               - payload or CRC word
//   wr_en/wr_addr/wr_data - registered payload write for the RX cache
//   res_valid/res_ready   - verdict handshake
//   res_req/res_crc/res_ok/res_frame_err - verdict fields
module rx_crc_checker
  import chiplet_types_pkg::*;
#(
  parameter int MAX_LEN = 128,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sop,
  input  logic [3:0]       in_req,
  input  logic [LEN_W-1:0] in_len,
  input  logic [31:0]      in_data,
  output logic             wr_en,
  output logic [LEN_W-1:0] wr_addr,
  output logic [31:0]      wr_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_req,
  output logic [31:0]      res_crc,
  output logic             res_ok,
  output logic             res_frame_err
);

  rx_crc_state_t    state_q, state_d;
  node_id_t         req_q, req_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  word_t            crc_q, crc_d;
  crc_result_t      res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             wr_en_q, wr_en_d;
  logic [LEN_W-1:0] wr_addr_q, wr_addr_d;
  word_t            wr_data_q, wr_data_d;

  word_t            crc_next;
  logic [LEN_W-1:0] len_clamped;
  logic             loads_result;
  logic             accept;

  crc32_word_update u_crc (
    .crc_i  (crc_q),
    .data_i (in_data),
    .crc_o  (crc_next)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    res_d       = res_q;
    res_valid_d = res_valid_q && !res_ready;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    len_clamped = (in_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : in_len;

    // A beat writes the verdict register if it is the CRC beat or an
    // aborting header; only those beats can be stalled by a held verdict.
    loads_result = (state_q != IDLE) && (in_sop || (state_q == CHECK));
    in_ready     = !(loads_result && res_valid_q && !res_ready);
    accept       = in_valid && in_ready;

    if (accept) begin
      if (loads_result) begin
        res_valid_d = 1'b1;
        res_d.req   = req_q;
        res_d.crc   = crc_q;
        if (in_sop) begin
          res_d.ok        = 1'b0;
          res_d.frame_err = 1'b1;
        end else begin
          res_d.ok        = (crc_q == in_data);
          res_d.frame_err = 1'b0;
        end
      end

      // An aborting header also opens the next packet in the same beat.
      if (in_sop) begin
        req_d   = in_req;
        len_d   = len_clamped;
        crc_d   = CRC32_INIT;
        cnt_d   = '0;
        state_d = (len_clamped != '0) ? PAYLOAD : CHECK;
      end else if (state_q == PAYLOAD) begin
        crc_d     = crc_next;
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = in_data;
        cnt_d     = cnt_q + LEN_W'(1);
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = CHECK;
        end
      end else if (state_q == CHECK) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      crc_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign res_valid     = res_valid_q;
  assign res_req       = res_q.req;
  assign res_crc       = res_q.crc;
  assign res_ok        = res_q.ok;
  assign res_frame_err = res_q.frame_err;

endmodule

// File: tb/tb_rx_crc_checker.sv
module tb_rx_crc_checker;
  import chiplet_types_pkg::*;

  localparam int MAX_LEN = 128;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk, rst;
  logic             in_valid, in_ready, in_sop;
  logic [3:0]       in_req;
  logic [LEN_W-1:0] in_len;
  logic [31:0]      in_data;
  logic             wr_en;
  logic [LEN_W-1:0] wr_addr;
  logic [31:0]      wr_data;
  logic             res_valid, res_ready;
  logic [3:0]       res_req;
  logic [31:0]      res_crc;
  logic             res_ok, res_frame_err;

  rx_crc_checker #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_req(in_req), .in_len(in_len), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_req(res_req), .res_crc(res_crc), .res_ok(res_ok),
    .res_frame_err(res_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: classic byte-at-a-time long division, MSB first.
  function automatic word_t crc_ref(input word_t c, input word_t w);
    word_t x;
    x = c;
    for (int b = 3; b >= 0; b--) begin
      x = x ^ (((w >> (8 * b)) & 32'hFF) << 24);
      for (int k = 0; k < 8; k++) x = x[31] ? ((x << 1) ^ CRC32_POLY) : (x << 1);
    end
    return x;
  endfunction

  // Packet-level reference model.
  bit          pkt_open = 0;
  node_id_t    m_req;
  word_t       m_crc;
  int          m_len, m_cnt;
  crc_result_t exp_res[$];
  int          exp_addr[$];
  word_t       exp_data[$];

  function automatic void model_beat(bit sop, node_id_t req, int len, word_t data);
    if (sop) begin
      if (pkt_open) exp_res.push_back('{m_req, m_crc, 1'b0, 1'b1});
      m_req = req; m_len = (len > MAX_LEN) ? MAX_LEN : len;
      m_crc = CRC32_INIT; m_cnt = 0; pkt_open = 1;
    end else if (pkt_open) begin
      if (m_cnt < m_len) begin
        exp_addr.push_back(m_cnt); exp_data.push_back(data);
        m_crc = crc_ref(m_crc, data); m_cnt++;
      end else begin
        exp_res.push_back('{m_req, m_crc, (m_crc == data), 1'b0});
        pkt_open = 0;
      end
    end
  endfunction

  int rr_mode = 1;   // 0: hold low, 1: hold high, 2: random
  bit gap_en  = 0;

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0: res_ready = 1'b0;
      1: res_ready = 1'b1;
      default: res_ready = 1'($urandom_range(1));
    endcase
  end

  task automatic send_beat(input bit sop, input node_id_t req, input int len, input word_t data);
    bit acc, rdy;
    in_valid = 1'b1; in_sop = sop; in_req = req; in_len = LEN_W'(len); in_data = data;
    acc = 0;
    for (int n = 0; n < 500 && !acc; n++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1; acc = rdy;
    end
    in_valid = 1'b0; in_sop = 1'b0;
    if (!acc) chk("in_ready_timeout", 0, 1);
    else model_beat(sop, req, len, data);
    if (gap_en && $urandom_range(3) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input node_id_t req, input int len, input word_t pl[$], input word_t crc_xor);
    word_t c;
    c = CRC32_INIT;
    send_beat(1, req, len, $urandom);
    foreach (pl[i]) begin
      send_beat(0, 0, 0, pl[i]);
      c = crc_ref(c, pl[i]);
    end
    send_beat(0, 0, 0, c ^ crc_xor);
  endtask

  function automatic void rand_payload(input int n, output word_t q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back($urandom);
  endfunction

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (exp_addr.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          chk("wr_addr", 64'(wr_addr), 64'(exp_addr.pop_front()));
          chk("wr_data", wr_data, exp_data.pop_front());
        end
      end
      if (res_valid) begin
        if (exp_res.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          chk("res_req", res_req, exp_res[0].req);
          chk("res_crc", res_crc, exp_res[0].crc);
          chk("res_ok", res_ok, exp_res[0].ok);
          chk("res_frame_err", res_frame_err, exp_res[0].frame_err);
          if (res_ready) void'(exp_res.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t pl[$];
    word_t gold;
    int n, lf, k;

    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_req = '0; in_len = '0; in_data = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", 64'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_req", res_req, 0);
    chk("rst_res_crc", res_crc, 0);
    chk("rst_res_ok", res_ok, 0);
    chk("rst_res_frame_err", res_frame_err, 0);
    @(posedge clk); #1;

    // Zero-length packet
    send_beat(1, 3, 0, 32'h0);
    send_beat(0, 0, 0, 32'hFFFFFFFF);
    chk("zl_res_valid", res_valid, 1);
    chk("zl_res_crc", res_crc, 32'hFFFFFFFF);
    chk("zl_res_ok", res_ok, 1);
    chk("zl_wr_en", wr_en, 0);
    @(posedge clk); #1;

    // Good and corrupted 4-word packet
    pl = '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h00000000};
    gold = CRC32_INIT;
    foreach (pl[i]) gold = crc_ref(gold, pl[i]);
    send_pkt(1, 4, pl, 32'h0);
    chk("good4_res_crc", res_crc, gold);
    chk("good4_res_ok", res_ok, 1);
    send_pkt(2, 4, pl, 32'h1);
    chk("bad4_res_crc", res_crc, gold);
    chk("bad4_res_ok", res_ok, 0);
    chk("bad4_frame_err", res_frame_err, 0);
    repeat (2) @(posedge clk); #1;

    // Backpressure on the second CRC beat
    rr_mode = 0;
    @(posedge clk); #1;
    fork
      begin
        rand_payload(2, pl); send_pkt(6, 2, pl, 0);
        rand_payload(3, pl); send_pkt(7, 3, pl, 0);
      end
      begin
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_res_valid_held", res_valid, 1);
        chk("bp_res_req_held", res_req, 6);
        rr_mode = 1;
      end
    join
    repeat (3) @(posedge clk); #1;

    // Abort by an unexpected header
    rand_payload(3, pl);
    send_beat(1, 4, 8, 0);
    foreach (pl[i]) send_beat(0, 0, 0, pl[i]);
    chk("abort_pending_none", res_valid, 0);
    rand_payload(1, pl);
    send_pkt(5, 1, pl, 0);
    chk("abort_second_req", res_req, 5);
    chk("abort_second_ok", res_ok, 1);
    repeat (2) @(posedge clk); #1;

    // Reset mid-packet
    send_beat(1, 9, 6, 0);
    send_beat(0, 0, 0, $urandom);
    send_beat(0, 0, 0, $urandom);
    @(posedge clk); #1;
    rst = 1'b1;
    pkt_open = 0; exp_res = {}; exp_addr = {}; exp_data = {};
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", 64'(wr_addr), 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_res_crc", res_crc, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    rand_payload(3, pl);
    send_pkt(10, 3, pl, 0);
    chk("post_rst_ok", res_ok, 1);
    repeat (2) @(posedge clk); #1;

    // Randomised traffic
    rr_mode = 2; gap_en = 1;
    for (int it = 0; it < 40; it++) begin
      if (!pkt_open && $urandom_range(4) == 0) send_beat(0, 0, 0, $urandom);
      k = $urandom_range(9);
      if (k == 0) begin n = 0; lf = 0; end
      else if (k == 1) begin n = MAX_LEN; lf = MAX_LEN; end
      else if (k == 2) begin n = MAX_LEN; lf = MAX_LEN + 1 + $urandom_range(100); end
      else begin n = 1 + $urandom_range(7); lf = n; end
      rand_payload(n, pl);
      if (n > 0 && $urandom_range(5) == 0) begin
        send_beat(1, 4'($urandom), lf, 0);
        for (int i = 0; i < $urandom_range(n - 1); i++) send_beat(0, 0, 0, pl[i]);
      end else begin
        send_pkt(4'($urandom), lf, pl, ($urandom_range(3) == 0) ? (32'h1 << $urandom_range(31)) : 32'h0);
      end
    end

    rr_mode = 1; gap_en = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_res_q", exp_res.size(), 0);
    chk("drain_wr_q", exp_addr.size(), 0);
    chk("drain_res_valid", res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
